// File: rtl/mux_stream_pkg.sv
// Shared constants and helpers for the N-channel stream multiplexer.
package mux_stream_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Ceiling log2, never below 1 so a 2-channel mux still has a 1-bit index.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        if (r < 1) r = 1;
        return r;
    endfunction

endpackage

// File: rtl/rr_arbiter_n.sv
// Round-robin arbiter: first requester at or after ptr wins, ptr moves past
// the winner only when the caller reports that the grant was consumed.
module rr_arbiter_n
    import mux_stream_pkg::*;
#(
    parameter  int NUM_CH = 4,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              advance,
    output logic [SEL_W-1:0]  grant_idx,
    output logic              grant_vld
);

    logic [SEL_W-1:0] ptr;

    // Search ptr, ptr+1, ... with wrap; one extra bit keeps the sum exact.
    always_comb begin : search_p
        logic [SEL_W:0]   sum;
        logic [SEL_W-1:0] idx;
        grant_idx = '0;
        grant_vld = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            sum = {1'b0, ptr} + (SEL_W+1)'(i);
            if (sum >= (SEL_W+1)'(NUM_CH)) sum = sum - (SEL_W+1)'(NUM_CH);
            idx = sum[SEL_W-1:0];
            if (!grant_vld && req[idx]) begin
                grant_vld = 1'b1;
                grant_idx = idx;
            end
        end
    end

    // Pointer advances past the consumed grant, wrapping at NUM_CH-1.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (advance && grant_vld) begin
            if (grant_idx == SEL_W'(NUM_CH - 1)) ptr <= '0;
            else                                 ptr <= grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/mux_stream_n.sv
// N-channel valid/ready stream mux with fixed-select or round-robin grant
// feeding a single registered output stage (1 beat/cycle, no skid buffer).
module mux_stream_n
    import mux_stream_pkg::*;
#(
    parameter  int NUM_CH = 4,
    parameter  int DATA_W = 8,
    localparam int SEL_W  = clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH-1:0]        in_valid,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    output logic [NUM_CH-1:0]        in_ready,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    input  logic                     out_ready
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [SEL_W-1:0]   arb_idx, grant_idx;
    logic               arb_vld, grant_vld;
    logic               load_en, in_xfer, advance;
    logic [DATA_W-1:0]  din;

    rr_arbiter_n #(.NUM_CH(NUM_CH)) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (in_valid),
        .advance   (advance),
        .grant_idx (arb_idx),
        .grant_vld (arb_vld)
    );

    // Mode mux: sel wins in fixed mode; out-of-range sel grants nobody.
    always_comb begin
        grant_idx = arb_idx;
        grant_vld = arb_vld;
        if (mode == MODE_FIXED) begin
            grant_idx = sel;
            grant_vld = (int'(sel) < NUM_CH);
        end
    end

    // Output slot can take a beat when empty or draining this cycle.
    assign load_en = (state_q == EMPTY) | out_ready;

    for (genvar k = 0; k < NUM_CH; k++) begin : g_rdy
        assign in_ready[k] = ~rst & load_en & grant_vld & (grant_idx == SEL_W'(k));
    end

    assign in_xfer = |(in_valid & in_ready);
    assign advance = in_xfer & (mode == MODE_RR);

    // Only the granted channel's data is routed toward the register.
    always_comb begin
        din = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (grant_vld && grant_idx == SEL_W'(k)) din = in_data[k*DATA_W +: DATA_W];
        end
    end

    // Output FSM next state: fill on input transfer, empty on drain without refill.
    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (in_xfer) state_d = FULL;
            FULL:    if (out_ready && !in_xfer) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // Output FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= EMPTY;
        else     state_q <= state_d;
    end

    // Beat/channel register, held stable unless a new beat is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data <= '0;
            out_ch   <= '0;
        end else if (in_xfer) begin
            out_data <= din;
            out_ch   <= grant_idx;
        end
    end

    assign out_valid = (state_q == FULL);

endmodule

// File: tb/tb_mux_stream_n.sv
module tb_mux_stream_n;

    logic        clk = 1'b0;
    logic        rst, mode, out_ready;
    logic [1:0]  sel;
    logic [3:0]  in_valid, in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [1:0]  out_ch;

    logic        mode3, out_ready3;
    logic [1:0]  sel3;
    logic [2:0]  in_valid3, in_ready3;
    logic [23:0] in_data3;
    logic        out_valid3;
    logic [7:0]  out_data3;
    logic [1:0]  out_ch3;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model state
    logic       m_valid;
    logic [7:0] m_data;
    int         m_ch;
    int         m_ptr;

    always #5 clk = ~clk;

    mux_stream_n #(.NUM_CH(4), .DATA_W(8)) dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready), .out_valid(out_valid),
        .out_data(out_data), .out_ch(out_ch), .out_ready(out_ready)
    );

    mux_stream_n #(.NUM_CH(3), .DATA_W(8)) dut3 (
        .clk(clk), .rst(rst), .mode(mode3), .sel(sel3), .in_valid(in_valid3),
        .in_data(in_data3), .in_ready(in_ready3), .out_valid(out_valid3),
        .out_data(out_data3), .out_ch(out_ch3), .out_ready(out_ready3)
    );

    function automatic int model_grant();
        if (mode == 1'b0) return (int'(sel) < 4) ? int'(sel) : -1;
        for (int i = 0; i < 4; i++) begin
            if (in_valid[(m_ptr + i) % 4]) return (m_ptr + i) % 4;
        end
        return -1;
    endfunction

    function automatic logic [3:0] model_rdy();
        int g;
        g = model_grant();
        if (rst || g < 0 || !(!m_valid || out_ready)) return 4'b0000;
        return 4'(1 << g);
    endfunction

    // advance one clock and update the model from the pre-edge inputs
    task automatic tick();
        int g;
        logic xf;
        logic [7:0] d;
        g  = model_grant();
        xf = (model_rdy() != 4'b0000) && in_valid[g];
        d  = (g >= 0) ? in_data[g*8 +: 8] : 8'h00;
        @(posedge clk);
        if (rst) begin
            m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 0;
        end else if (xf) begin
            m_valid = 1'b1; m_data = d; m_ch = g;
            if (mode) m_ptr = (g + 1) % 4;
        end else if (m_valid && out_ready) begin
            m_valid = 1'b0;
        end
        #1;
    endtask

    task automatic set_data4(input logic [7:0] d0, input logic [7:0] d1,
                             input logic [7:0] d2, input logic [7:0] d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 4'b1111; mode = 1'b1; out_ready = 1'b1;
        in_valid3 = 3'b111;
        set_data4(8'h10, 8'h11, 8'h12, 8'h13);
        for (int c = 0; c < 2; c++) begin
            #1;
            n_tests++;
            if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_in_ready got %b exp 0000", in_ready); end
            tick();
            n_tests++;
            if ({out_valid, out_data, out_ch} !== 11'd0) begin
                n_fail++; $display("FAIL reset_outputs got v=%b d=%h ch=%0d exp 0/00/0", out_valid, out_data, out_ch);
            end
        end
        in_valid3 = 3'b000;
        rst = 1'b0;
        #1;
        n_tests++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL post_reset_rdy got %b exp 0001", in_ready); end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
            n_fail++; $display("FAIL first_beat got v=%b ch=%0d d=%h exp 1/0/10", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_fixed();
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0100; out_ready = 1'b1;
        set_data4(8'h00, 8'h00, 8'hA5, 8'h00);
        #1;
        n_tests++;
        if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL fixed_rdy got %b exp 0100", in_ready); end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
            n_fail++; $display("FAIL fixed_beat got v=%b d=%h ch=%0d exp 1/a5/2", out_valid, out_data, out_ch);
        end
        sel = 2'd1;
        #1;
        n_tests++;
        if (in_ready !== 4'b0010) begin n_fail++; $display("FAIL fixed_idle_rdy got %b exp 0010", in_ready); end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fixed_idle_valid got %b exp 0", out_valid); end
        end
    endtask

    task automatic test_rr();
        int exp_alt[4];
        exp_alt = '{3, 1, 3, 1};
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 1'b1; in_valid = 4'b1111; out_ready = 1'b1;
        set_data4(8'h10, 8'h11, 8'h12, 8'h13);
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || int'(out_ch) != i % 4 || out_data !== 8'(8'h10 + i % 4)) begin
                n_fail++; $display("FAIL rr_all[%0d] got v=%b ch=%0d d=%h exp ch=%0d", i, out_valid, out_ch, out_data, i % 4);
            end
        end
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || int'(out_ch) != exp_alt[i]) begin
                n_fail++; $display("FAIL rr_alt[%0d] got v=%b ch=%0d exp ch=%0d", i, out_valid, out_ch, exp_alt[i]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] hd;
        logic [1:0] hc;
        hd = out_data; hc = out_ch;
        in_valid = 4'b1111; out_ready = 1'b0;
        n_tests++;
        if (hc !== 2'd1 || hd !== 8'h11) begin n_fail++; $display("FAIL bp_start got ch=%0d d=%h exp 1/11", hc, hd); end
        for (int c = 0; c < 3; c++) begin
            #1;
            n_tests++;
            if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_rdy got %b exp 0000", in_ready); end
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || out_data !== hd || out_ch !== hc) begin
                n_fail++; $display("FAIL bp_hold got v=%b d=%h ch=%0d exp 1/%h/%0d", out_valid, out_data, out_ch, hd, hc);
            end
        end
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 4'b0100) begin n_fail++; $display("FAIL bp_release_rdy got %b exp 0100", in_ready); end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_ch !== 2'd2 || out_data !== 8'h12) begin
            n_fail++; $display("FAIL bp_reload got v=%b ch=%0d d=%h exp 1/2/12", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_nonpow2();
        mode3 = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111; out_ready3 = 1'b1;
        in_data3 = {8'h5C, 8'h22, 8'h11};
        #1;
        n_tests++;
        if (in_ready3 !== 3'b000) begin n_fail++; $display("FAIL n3_sel3_rdy got %b exp 000", in_ready3); end
        tick();
        n_tests++;
        if (out_valid3 !== 1'b0) begin n_fail++; $display("FAIL n3_sel3_valid got %b exp 0", out_valid3); end
        sel3 = 2'd2;
        #1;
        n_tests++;
        if (in_ready3 !== 3'b100) begin n_fail++; $display("FAIL n3_sel2_rdy got %b exp 100", in_ready3); end
        tick();
        n_tests++;
        if (out_valid3 !== 1'b1 || out_data3 !== 8'h5C || out_ch3 !== 2'd2) begin
            n_fail++; $display("FAIL n3_sel2_beat got v=%b d=%h ch=%0d exp 1/5c/2", out_valid3, out_data3, out_ch3);
        end
        in_valid3 = 3'b000;
    endtask

    task automatic test_reset_mid();
        rst = 1'b1; tick(); rst = 1'b0;
        mode = 1'b1; in_valid = 4'b0010; out_ready = 1'b1;
        set_data4(8'h10, 8'h11, 8'h12, 8'h13);
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_ch !== 2'd1) begin n_fail++; $display("FAIL mid_setup got v=%b ch=%0d exp 1/1", out_valid, out_ch); end
        out_ready = 1'b0; in_valid = 4'b1111; rst = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_rst_rdy got %b exp 0000", in_ready); end
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", out_valid); end
        rst = 1'b0; out_ready = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_restart_rdy got %b exp 0001", in_ready); end
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== 8'h10) begin
            n_fail++; $display("FAIL mid_restart_beat got v=%b ch=%0d d=%h exp 1/0/10", out_valid, out_ch, out_data);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst       = ($urandom_range(0, 39) == 0);
            mode      = ($urandom_range(0, 3) != 0);
            sel       = 2'($urandom_range(0, 3));
            in_valid  = 4'($urandom);
            in_data   = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            n_tests++;
            if (in_ready !== model_rdy()) begin
                n_fail++; $display("FAIL rand_rdy[%0d] got %b exp %b", c, in_ready, model_rdy());
            end
            tick();
            n_tests++;
            if (out_valid !== m_valid || out_data !== m_data || int'(out_ch) != m_ch) begin
                n_fail++; $display("FAIL rand_out[%0d] got v=%b d=%h ch=%0d exp v=%b d=%h ch=%0d",
                                   c, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'b0; in_data = 32'h0; out_ready = 1'b0;
        mode3 = 1'b0; sel3 = 2'd0; in_valid3 = 3'b0; in_data3 = 24'h0; out_ready3 = 1'b1;
        m_valid = 1'b0; m_data = 8'h00; m_ch = 0; m_ptr = 0;
        test_reset();
        test_fixed();
        test_rr();
        test_backpressure();
        test_nonpow2();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
